cla_nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder that processes operands four bits per cycle through one internal 4-bit carry-lookahead slice, carrying between nibbles in a register. It sits upstream of the result consumers in the arithmetic datapath and feeds the 4-bit CLA slice one nibble pair and carry at a time. It trades latency for area when wide additions are infrequent. Operands enter and results leave through valid/ready handshakes.

---
 rtl/cla_nibble_serial_adder.sv | 140 ++++++++++++++
 tb/tb_cla_nibble_serial_adder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice per cycle, carry held in a register.
// Optional signed-overflow flag output enabled by defining CLA_OVF_FLAG_EN.
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [3:0] nib_a, nib_b, nib_g, nib_p, nib_sum;
    logic [4:0] nib_c;

    // Single 4-bit lookahead slice; every carry is a flat function of g/p and the slice carry-in.
    always_comb begin
        nib_a    = a_q[4*idx_q +: 4];
        nib_b    = b_q[4*idx_q +: 4];
        nib_g    = nib_a & nib_b;
        nib_p    = nib_a ^ nib_b;
        nib_c[0] = carry_q;
        nib_c[1] = nib_g[0] | (nib_p[0] & carry_q);
        nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry_q);
        nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
        nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
        nib_sum  = nib_p ^ nib_c[3:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = nib_sum;
                carry_d             = nib_c[4];
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

`ifdef CLA_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // Overflow is the carry into the MSB xor the carry out of it, taken from the top nibble pass.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == RUN && idx_q == LAST_IDX) begin
            ovf_d = nib_c[3] ^ nib_c[4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed bench for cla_nibble_serial_adder (WIDTH=16): scoreboard of expected results,
// immediate-assertion checks, latency/back-pressure/reset coverage.
module tb_cla_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_OVF_FLAG_EN
    logic             ovf;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // {ovf, cout, sum}
    logic [WIDTH+1:0] exp_q[$];

    cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
`ifdef CLA_OVF_FLAG_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c);
        logic [WIDTH:0] full;
        logic           v;
        full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        v    = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return {v, full[WIDTH], full[WIDTH-1:0]};
    endfunction

    // Present operands, wait for acceptance, push the expectation, then measure latency to out_valid.
    task automatic issue(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic c, input bit check_lat);
        int waited;
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back(model(x, y, c));
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        if (check_lat) begin
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
                if (lat < NIB) check({tag, "_no_early_valid"}, 32'(out_valid), 32'd0);
            end
            check({tag, "_latency"}, 32'(lat), 32'(NIB));
        end
    endtask

    // Hold back-pressure for 'hold' cycles with noisy inputs, then consume and compare.
    task automatic collect(input string tag, input int hold);
        logic [WIDTH+1:0] e;
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            check({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_bp_sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
            check({tag, "_bp_cout"}, 32'(cout), 32'(e[WIDTH]));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(e[WIDTH]));
`ifdef CLA_OVF_FLAG_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(e[WIDTH+1]));
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef CLA_OVF_FLAG_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        issue("t1", 16'h1234, 16'h4321, 1'b0, 1'b1);
        collect("t1", 0);
        issue("t2", 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        collect("t2", 0);
        issue("t3", 16'h0F0F, 16'h0F01, 1'b0, 1'b1);
        collect("t3", 0);
        issue("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        collect("ovf_pos", 0);
        issue("ovf_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        collect("ovf_wrap", 0);
        issue("neg_ovf", 16'h8000, 16'h8000, 1'b1, 1'b1);
        collect("neg_ovf", 0);

        issue("bp", 16'hA5C3, 16'h5A3C, 1'b1, 1'b1);
        collect("bp", 10);

        // Abort mid-RUN: reset lands while idx=2 is being processed.
        issue("rst_mid", 16'hBEEF, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
`ifdef CLA_OVF_FLAG_EN
        check("abort_ovf", 32'(ovf), 32'd0);
`endif
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        issue("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b1);
        collect("post_rst", 0);

        for (int i = 0; i < 8; i++) begin
            issue("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            collect("rand", int'($urandom_range(0, 3)));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
